// File: rtl/cpu_bus_ctl.sv
// cpu_bus_ctl: decodes 6502 core accesses into ROM, SRAM or the IO page and returns read data.
// Latency: IDLE + L BUSY + DONE cycles (ROM 2, IO 1, SRAM SRAM_WAIT+1); cpu_ce low for L+1 of them.
// Backpressure: cpu_ce stalls the core; CPU_BUS_IOWAIT_EN adds io_ready with an IO_TIMEOUT bound.
module cpu_bus_ctl #(
    parameter int unsigned SRAM_WAIT  = 2,
    parameter logic [7:0]  IO_BASE    = 8'hC0,
    parameter int unsigned IO_TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_o_data,
    input  logic        cpu_wren,
    input  logic        cpu_read,
    output logic [7:0]  cpu_i_data,
    output logic        cpu_ce,
    output logic [13:0] rom_addr,
    input  logic [7:0]  rom_din,
    output logic [15:0] sram_addr,
    output logic [7:0]  sram_dout,
    input  logic [7:0]  sram_din,
    output logic        sram_we,
    output logic        sram_oe,
    output logic [7:0]  io_addr,
    output logic [7:0]  io_dout,
    input  logic [7:0]  io_din,
`ifdef CPU_BUS_IOWAIT_EN
    input  logic        io_ready,
`endif
    output logic        io_wr,
    output logic        io_rd
);

    localparam int unsigned SRAM_L   = SRAM_WAIT + 1;
    // Counter is sized for the longer of the SRAM wait and the IO timeout.
    localparam int unsigned MAX_LOAD = (IO_TIMEOUT > SRAM_L) ? IO_TIMEOUT : SRAM_L;
    localparam int unsigned CNT_W    = $clog2(MAX_LOAD + 1);

    localparam logic [CNT_W-1:0] LD_ROM  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LD_SRAM = CNT_W'(SRAM_WAIT);
`ifdef CPU_BUS_IOWAIT_EN
    localparam logic [CNT_W-1:0] LD_IO   = CNT_W'(IO_TIMEOUT - 1);
`else
    localparam logic [CNT_W-1:0] LD_IO   = '0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
    typedef enum logic [1:0] {Z_ROM, Z_SRAM, Z_IO} zone_e;

    state_e           state_q, state_d;
    zone_e            zone_q, zone_d, zone_in;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             wr_q, wr_d;
    logic [7:0]       rdata_q, rdata_d;
    logic [7:0]       rd_mux;
    logic             req;
    logic             busy;

    assign req  = cpu_read | cpu_wren;
    assign busy = (state_q == S_BUSY);

    always_comb begin
        if (cpu_address[15:8] == IO_BASE) begin
            zone_in = Z_IO;
        end else if (cpu_address[15:14] == 2'b11) begin
            zone_in = Z_ROM;
        end else begin
            zone_in = Z_SRAM;
        end
    end

    always_comb begin
        case (zone_q)
            Z_ROM:   rd_mux = rom_din;
            Z_SRAM:  rd_mux = sram_din;
            default: rd_mux = io_din;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        zone_d  = zone_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d  = cpu_address;
                    wdata_d = cpu_o_data;
                    wr_d    = cpu_wren;
                    zone_d  = zone_in;
                    case (zone_in)
                        Z_ROM:   cnt_d = LD_ROM;
                        Z_SRAM:  cnt_d = LD_SRAM;
                        default: cnt_d = LD_IO;
                    endcase
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
`ifdef CPU_BUS_IOWAIT_EN
                if (zone_q == Z_IO) begin
                    if (io_ready) begin
                        if (!wr_q) rdata_d = io_din;
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else if (cnt_q == '0) begin
                        // Peripheral never answered: reads see all-ones, writes are dropped.
                        if (!wr_q) rdata_d = 8'hFF;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end else
`endif
                if (cnt_q == '0) begin
                    if (!wr_q) rdata_d = rd_mux;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            zone_q  <= Z_ROM;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            zone_q  <= zone_d;
            rdata_q <= rdata_d;
        end
    end

    // Bus outputs come straight from the latched request, so they are stable for all of BUSY.
    assign cpu_ce     = ((state_q == S_IDLE) && !req) || (state_q == S_DONE);
    assign cpu_i_data = rdata_q;
    assign rom_addr   = addr_q[13:0];
    assign sram_addr  = addr_q;
    assign sram_dout  = wdata_q;
    assign io_addr    = addr_q[7:0];
    assign io_dout    = wdata_q;
    assign sram_we    = busy && (zone_q == Z_SRAM) && wr_q;
    assign sram_oe    = busy && (zone_q == Z_SRAM) && !wr_q;
    assign io_wr      = busy && (zone_q == Z_IO) && wr_q;
    assign io_rd      = busy && (zone_q == Z_IO) && !wr_q;

endmodule
